// File: rtl/udmc_pkg.sv
// udmc_pkg: shared constants and types for the up/down modulo counter.
//   DIR_UP / DIR_DOWN    : encodings of the 'up' input
//   MODE_WRAP / MODE_SAT : encodings of the 'sat_mode' input
//   udmc_bnd_e           : boundary-event classification from the next-state logic
package udmc_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Which edge of the 0..limit range an update ran into, if any.
    typedef enum logic [1:0] {
        BND_NONE = 2'd0,
        BND_HIGH = 2'd1,   // up-count went past limit
        BND_LOW  = 2'd2    // down-count went below zero
    } udmc_bnd_e;

endpackage

// File: rtl/udmc_next.sv
// udmc_next: combinational next-count logic for one enabled update.
// Ports:
//   count_i    : current count
//   step_i     : increment / decrement magnitude
//   limit_i    : inclusive upper bound of the range 0..limit
//   up_i       : direction (DIR_UP / DIR_DOWN)
//   sat_mode_i : boundary behaviour (MODE_WRAP / MODE_SAT)
//   next_o     : count after this update
//   bnd_o      : 1 when the update is a boundary event
module udmc_next
    import udmc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic             up_i,
    input  logic             sat_mode_i,
    output logic [WIDTH-1:0] next_o,
    output logic             bnd_o
);

    logic [WIDTH:0] sum;
    logic           above;
    udmc_bnd_e      bnd;

    // One extra bit so count+step never wraps before it is compared to limit.
    assign sum   = {1'b0, count_i} + {1'b0, step_i};
    assign above = (count_i > limit_i);

    always_comb begin
        bnd    = BND_NONE;
        next_o = count_i;
        if (step_i == '0) begin
            // Holding still, but a count stranded above a lowered limit is
            // still pulled back into range.
            if (above) next_o = limit_i;
        end else if (up_i == DIR_UP) begin
            if (sum <= {1'b0, limit_i}) begin
                next_o = sum[WIDTH-1:0];
            end else begin
                bnd    = BND_HIGH;
                next_o = (sat_mode_i == MODE_SAT) ? limit_i : '0;
            end
        end else begin
            if (above) begin
                // Limit lowered under us: clamp, not a boundary event.
                next_o = limit_i;
            end else if (step_i <= count_i) begin
                next_o = count_i - step_i;
            end else begin
                bnd    = BND_LOW;
                next_o = (sat_mode_i == MODE_SAT) ? '0 : limit_i;
            end
        end
    end

    assign bnd_o = (bnd != BND_NONE);

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo counter with programmable step and limit,
// wrap or saturate at the range edges, terminal-count pulse, sticky boundary
// flag and (optionally) a compare-match pulse.
// Optional feature macro: UDMC_CMP_EN adds cmp_val / cmp_match.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-low reset
//   en        : count enable
//   up        : 1 = count up, 0 = count down
//   step      : step magnitude
//   limit     : inclusive upper bound
//   sat_mode  : 1 = saturate, 0 = wrap
//   load      : synchronous parallel load (beats en)
//   load_val  : value to load, clamped to limit
//   count     : registered count
//   tc        : one-cycle terminal-count pulse on each boundary event
//   ovf       : sticky boundary flag, cleared by load or reset
//   cmp_val   : compare value            (UDMC_CMP_EN only)
//   cmp_match : registered compare pulse (UDMC_CMP_EN only)
module updown_mod_counter
    import udmc_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UDMC_CMP_EN
    input  logic [WIDTH-1:0] cmp_val,
    output logic             cmp_match,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_nxt;
    logic             step_bnd;
    logic [WIDTH-1:0] load_clamped;
    logic             upd;

    udmc_next #(.WIDTH(WIDTH)) u_next (
        .count_i    (count_q),
        .step_i     (step),
        .limit_i    (limit),
        .up_i       (up),
        .sat_mode_i (sat_mode),
        .next_o     (step_nxt),
        .bnd_o      (step_bnd)
    );

    assign load_clamped = (load_val > limit) ? limit : load_val;

    // High when this edge writes a new count value (load or enabled update).
    assign upd = load | en;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (load) begin
            count_d = load_clamped;
            ovf_d   = 1'b0;
        end else if (en) begin
            count_d = step_nxt;
            tc_d    = step_bnd;
            ovf_d   = ovf_q | step_bnd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= SEED;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef UDMC_CMP_EN
    logic cmp_q, cmp_d;

    // Fires whenever a load or enabled update lands on cmp_val, so it stays
    // high across consecutive writes of that same value.
    assign cmp_d = upd && (count_d == cmp_val);

    always_ff @(posedge clk) begin
        if (!rst) cmp_q <= 1'b0;
        else      cmp_q <= cmp_d;
    end

    assign cmp_match = cmp_q;
`else
    logic unused_upd;
    assign unused_upd = upd;
`endif

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, en, up, sat_mode, load;
    logic [W-1:0] step, limit, load_val;
    logic [W-1:0] count;
    logic         tc, ovf;
    logic [W-1:0] cmp_val;
    logic         cmp_match;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(W), .SEED(8'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .step      (step),
        .limit     (limit),
        .sat_mode  (sat_mode),
        .load      (load),
        .load_val  (load_val),
`ifdef UDMC_CMP_EN
        .cmp_val   (cmp_val),
        .cmp_match (cmp_match),
`endif
        .count     (count),
        .tc        (tc),
        .ovf       (ovf)
    );

`ifndef UDMC_CMP_EN
    assign cmp_match = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] c;
        logic         t;
        logic         o;
        logic         m;
        string        tag;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Push expectation for the edge about to happen, then pop and compare
    // once the DUT has produced that edge's outputs.
    task automatic cyc(input logic [W-1:0] c, input logic t, input logic o,
                       input logic m, input string tag);
        exp_t e;
        e.c = c; e.t = t; e.o = o; e.m = m; e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        n_chk++;
        assert (count === e.c) n_pass++;
        else $error("FAIL %s count got %0d exp %0d", e.tag, count, e.c);
        n_chk++;
        assert (tc === e.t) n_pass++;
        else $error("FAIL %s tc got %b exp %b", e.tag, tc, e.t);
        n_chk++;
        assert (ovf === e.o) n_pass++;
        else $error("FAIL %s ovf got %b exp %b", e.tag, ovf, e.o);
`ifdef UDMC_CMP_EN
        n_chk++;
        assert (cmp_match === e.m) n_pass++;
        else $error("FAIL %s cmp_match got %b exp %b", e.tag, cmp_match, e.m);
`endif
    endtask

    task automatic do_load(input logic [W-1:0] v, input logic [W-1:0] lim,
                           input logic [W-1:0] exp_c, input string tag);
        load = 1'b1; en = 1'b0; load_val = v; limit = lim;
        cyc(exp_c, 1'b0, 1'b0, 1'b0, tag);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; sat_mode = 1'b0; load = 1'b0;
        step = '0; limit = 8'd100; load_val = '0; cmp_val = 8'd238;

        // reset
        cyc(8'd0, 1'b0, 1'b0, 1'b0, "reset");
        rst = 1'b1;

        // load above limit clamps
        do_load(8'd200, 8'd100, 8'd100, "load_clamp");

        // up, wrap, limit 9, step 3
        do_load(8'd0, 8'd9, 8'd0, "load0");
        en = 1'b1; up = 1'b1; sat_mode = 1'b0; step = 8'd3;
        cyc(8'd3, 1'b0, 1'b0, 1'b0, "upwrap3");
        cyc(8'd6, 1'b0, 1'b0, 1'b0, "upwrap6");
        cyc(8'd9, 1'b0, 1'b0, 1'b0, "upwrap9");
        cyc(8'd0, 1'b1, 1'b1, 1'b0, "upwrap0");
        cyc(8'd3, 1'b0, 1'b1, 1'b0, "upwrap_after");

        // down, saturate, limit 50, step 7
        do_load(8'd10, 8'd50, 8'd10, "load10");
        en = 1'b1; up = 1'b0; sat_mode = 1'b1; step = 8'd7;
        cyc(8'd3, 1'b0, 1'b0, 1'b0, "dnsat3");
        cyc(8'd0, 1'b1, 1'b1, 1'b0, "dnsat0a");
        cyc(8'd0, 1'b1, 1'b1, 1'b0, "dnsat0b");
        do_load(8'd20, 8'd50, 8'd20, "load20_clr");

        // en low holds
        cyc(8'd20, 1'b0, 1'b0, 1'b0, "hold");

        // lowered limit: up wraps with tc, down clamps without
        do_load(8'd80, 8'd100, 8'd80, "load80a");
        limit = 8'd40; en = 1'b1; up = 1'b1; sat_mode = 1'b0; step = 8'd1;
        cyc(8'd0, 1'b1, 1'b1, 1'b0, "lowlim_up");
        do_load(8'd80, 8'd100, 8'd80, "load80b");
        limit = 8'd40; en = 1'b1; up = 1'b0;
        cyc(8'd40, 1'b0, 1'b0, 1'b0, "lowlim_dn");
        cyc(8'd39, 1'b0, 1'b0, 1'b0, "lowlim_dn2");

        // up saturate stays at limit with tc held
        do_load(8'd45, 8'd50, 8'd45, "load45");
        en = 1'b1; up = 1'b1; sat_mode = 1'b1; step = 8'd7;
        cyc(8'd50, 1'b1, 1'b1, 1'b0, "upsat_a");
        cyc(8'd50, 1'b1, 1'b1, 1'b0, "upsat_b");

        // down wrap goes to limit
        do_load(8'd2, 8'd9, 8'd2, "load2");
        en = 1'b1; up = 1'b0; sat_mode = 1'b0; step = 8'd3;
        cyc(8'd9, 1'b1, 1'b1, 1'b0, "dnwrap");

        // limit 0: every enabled step is a boundary event
        limit = 8'd0; up = 1'b1; step = 8'd5;
        cyc(8'd0, 1'b1, 1'b1, 1'b0, "lim0_a");
        cyc(8'd0, 1'b1, 1'b1, 1'b0, "lim0_b");

        // rst beats load and en
        rst = 1'b0; load = 1'b1; en = 1'b1; load_val = 8'd77; limit = 8'd100;
        cyc(8'd0, 1'b0, 1'b0, 1'b0, "rst_prio");
        // load beats en, no step applied
        rst = 1'b1; load_val = 8'd30; step = 8'd5; up = 1'b1;
        cyc(8'd30, 1'b0, 1'b0, 1'b0, "load_prio");
        load = 1'b0;

        // step 0 holds without tc
        step = 8'd0;
        cyc(8'd30, 1'b0, 1'b0, 1'b0, "step0");

        // full-width sum must not truncate: 100+200 > 255
        do_load(8'd100, 8'd255, 8'd100, "load100");
        en = 1'b1; up = 1'b1; sat_mode = 1'b0; step = 8'd200;
        cyc(8'd0, 1'b1, 1'b1, 1'b0, "wide_wrap");

        // compare match
        do_load(8'd0, 8'd100, 8'd0, "load0_cmp");
        cmp_val = 8'd6; en = 1'b1; up = 1'b1; step = 8'd2;
        cyc(8'd2, 1'b0, 1'b0, 1'b0, "cmp2");
        cyc(8'd4, 1'b0, 1'b0, 1'b0, "cmp4");
        cyc(8'd6, 1'b0, 1'b0, 1'b1, "cmp6");
        cyc(8'd8, 1'b0, 1'b0, 1'b0, "cmp8");
        en = 1'b0;
        cyc(8'd8, 1'b0, 1'b0, 1'b0, "cmp_idle");

        if (q.size() != 0) begin
            n_chk++;
            $error("FAIL scoreboard leftover got %0d exp 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
